// File: rtl/lcd_seq_pkg.sv
// Shared types and field positions for the LCD write sequencer.
package lcd_seq_pkg;

  localparam int unsigned LCD_ON_BIT   = 31;
  localparam int unsigned LCD_EN_BIT   = 10;
  localparam int unsigned LCD_RS_BIT   = 9;
  localparam int unsigned LCD_RW_BIT   = 8;
  localparam int unsigned LCD_DATA_MSB = 7;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StExec
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       long_cmd;
  } lcd_req_t;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_write_sequencer.sv
// Turns edge-triggered writes of the IO LCD control word into timed HD44780 write cycles,
// with a one-entry pending slot, a busy flag and a sticky overflow flag.
module lcd_write_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_PW_CYC    = 25,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_CLEAR_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_busy,
  output logic        o_lcd_ovf
);

  localparam int unsigned Max1   = (T_SETUP_CYC > T_PW_CYC) ? T_SETUP_CYC : T_PW_CYC;
  localparam int unsigned Max2   = (Max1 > T_HOLD_CYC) ? Max1 : T_HOLD_CYC;
  localparam int unsigned Max3   = (Max2 > T_EXEC_CYC) ? Max2 : T_EXEC_CYC;
  localparam int unsigned MaxCyc = (Max3 > T_CLEAR_CYC) ? Max3 : T_CLEAR_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] SetupLd = CntW'(T_SETUP_CYC - 1);
  localparam logic [CntW-1:0] PwLd    = CntW'(T_PW_CYC - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(T_HOLD_CYC - 1);
  localparam logic [CntW-1:0] ExecLd  = CntW'(T_EXEC_CYC - 1);
  localparam logic [CntW-1:0] ClearLd = CntW'(T_CLEAR_CYC - 1);

  lcd_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  lcd_req_t        cur_q;
  lcd_req_t        pend_q;
  logic            pend_vld_q;
  logic            en_prev_q;
  logic            en_q;
  logic            on_q;
  logic            ovf_q;

  logic     req;
  logic     exec_last;
  lcd_req_t new_req;
  logic     unused_bits;

  assign unused_bits = ^{i_io_lcd[30:11], i_io_lcd[LCD_RW_BIT]};

  always_comb begin
    req              = i_io_lcd[LCD_EN_BIT] && !en_prev_q;
    exec_last        = (state_q == StExec) && (cnt_q == '0);
    new_req.rs       = i_io_lcd[LCD_RS_BIT];
    new_req.data     = i_io_lcd[LCD_DATA_MSB:0];
    new_req.long_cmd = is_long_cmd(i_io_lcd[LCD_RS_BIT], i_io_lcd[LCD_DATA_MSB:0]);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      en_prev_q  <= 1'b0;
      en_q       <= 1'b0;
      on_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      en_prev_q <= i_io_lcd[LCD_EN_BIT];
      on_q      <= i_io_lcd[LCD_ON_BIT];

      unique case (state_q)
        StIdle: begin
          if (req) begin
            cur_q   <= new_req;
            cnt_q   <= SetupLd;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            cnt_q   <= PwLd;
            en_q    <= 1'b1;
            state_q <= StPulse;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            cnt_q   <= HoldLd;
            en_q    <= 1'b0;
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            cnt_q   <= cur_q.long_cmd ? ClearLd : ExecLd;
            state_q <= StExec;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            if (pend_vld_q) begin
              cur_q      <= pend_q;
              pend_vld_q <= 1'b0;
              cnt_q      <= SetupLd;
              state_q    <= StSetup;
            end else if (req) begin
              // Slot fill and pop collapse into one edge: straight back to SETUP.
              cur_q   <= new_req;
              cnt_q   <= SetupLd;
              state_q <= StSetup;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          en_q    <= 1'b0;
          state_q <= StIdle;
        end
      endcase

      if (req && (state_q != StIdle)) begin
        if (pend_vld_q) begin
          ovf_q <= 1'b1;
        end else if (!exec_last) begin
          pend_q     <= new_req;
          pend_vld_q <= 1'b1;
        end
      end
    end
  end

  assign o_lcd_on   = on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = cur_q.rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = cur_q.data;
  assign o_lcd_busy = (state_q != StIdle) || pend_vld_q;
  assign o_lcd_ovf  = ovf_q;

endmodule
